// File: rtl/ads7254_sample_avg.sv
// Offset removal and iSYNC-aligned boxcar averaging of ADS7254 channel A/B sample pairs.
// Emits one signed 16-bit averaged pair per 2^LOG2_N-sample window with a one-cycle strobe.
module ads7254_sample_avg #(
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned LOG2_N   = 3,
    parameter int unsigned OFFSET_A = 2048,
    parameter int unsigned OFFSET_B = 2048
) (
    input  logic              iCLK_100,
    input  logic              iRST,
    input  logic              iSYNC,
    input  logic              ivalid,
    input  logic [DATA_W-1:0] idata_ch_A,
    input  logic [DATA_W-1:0] idata_ch_B,
    output logic [15:0]       odata_ch_A,
    output logic [15:0]       odata_ch_B,
    output logic              ovalid,
    output logic              oerr
);

    localparam int unsigned SW = DATA_W + 1;
    localparam int unsigned AW = SW + LOG2_N;
    localparam int unsigned CW = LOG2_N + 1;
    localparam logic [CW-1:0] CntLast = CW'((1 << LOG2_N) - 1);

    typedef enum logic [0:0] {StWaitSync, StAccum} state_e;

    state_e               state_q, state_d;
    logic                 sync_q;
    logic signed [AW-1:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [15:0]          odata_a_q, odata_a_d, odata_b_q, odata_b_d;
    logic                 ovalid_q, ovalid_d;
    logic                 oerr_q, oerr_d;

    logic                 sync_rise;
    logic signed [SW-1:0] s_a, s_b;
    logic signed [AW-1:0] s_a_ext, s_b_ext;
    logic signed [AW-1:0] base_a, base_b, sum_a, sum_b;
    logic [CW-1:0]        base_cnt;
    logic signed [SW-1:0] avg_a, avg_b;
    logic signed [15:0]   avg_a_ext, avg_b_ext;
    logic                 take;

    assign sync_rise = iSYNC & ~sync_q;

    assign s_a = $signed({1'b0, idata_ch_A}) - $signed(SW'(OFFSET_A));
    assign s_b = $signed({1'b0, idata_ch_B}) - $signed(SW'(OFFSET_B));
    assign s_a_ext = s_a;
    assign s_b_ext = s_b;

    // A restart discards the running window, so the incoming sample starts from zero.
    assign base_a   = sync_rise ? '0 : acc_a_q;
    assign base_b   = sync_rise ? '0 : acc_b_q;
    assign base_cnt = sync_rise ? '0 : cnt_q;

    assign sum_a = base_a + s_a_ext;
    assign sum_b = base_b + s_b_ext;

    // The window mean always fits in SW bits, so the upper accumulator bits are pure sign.
    assign avg_a     = SW'(sum_a >>> LOG2_N);
    assign avg_b     = SW'(sum_b >>> LOG2_N);
    assign avg_a_ext = avg_a;
    assign avg_b_ext = avg_b;

    always_comb begin
        state_d   = state_q;
        acc_a_d   = acc_a_q;
        acc_b_d   = acc_b_q;
        cnt_d     = cnt_q;
        odata_a_d = odata_a_q;
        odata_b_d = odata_b_q;
        ovalid_d  = 1'b0;
        oerr_d    = oerr_q;
        take      = 1'b0;

        unique case (state_q)
            StWaitSync: take = sync_rise;
            StAccum: begin
                take = 1'b1;
                if (sync_rise && cnt_q != '0) begin
                    oerr_d = 1'b1;
                end
            end
            default: take = 1'b0;
        endcase

        if (sync_rise) begin
            state_d = StAccum;
        end

        if (take) begin
            acc_a_d = base_a;
            acc_b_d = base_b;
            cnt_d   = base_cnt;
            if (ivalid) begin
                if (base_cnt == CntLast) begin
                    odata_a_d = avg_a_ext;
                    odata_b_d = avg_b_ext;
                    ovalid_d  = 1'b1;
                    acc_a_d   = '0;
                    acc_b_d   = '0;
                    cnt_d     = '0;
                end else begin
                    acc_a_d = sum_a;
                    acc_b_d = sum_b;
                    cnt_d   = base_cnt + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge iCLK_100) begin
        if (iRST) begin
            state_q   <= StWaitSync;
            sync_q    <= 1'b0;
            acc_a_q   <= '0;
            acc_b_q   <= '0;
            cnt_q     <= '0;
            odata_a_q <= '0;
            odata_b_q <= '0;
            ovalid_q  <= 1'b0;
            oerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= iSYNC;
            acc_a_q   <= acc_a_d;
            acc_b_q   <= acc_b_d;
            cnt_q     <= cnt_d;
            odata_a_q <= odata_a_d;
            odata_b_q <= odata_b_d;
            ovalid_q  <= ovalid_d;
            oerr_q    <= oerr_d;
        end
    end

    assign odata_ch_A = odata_a_q;
    assign odata_ch_B = odata_b_q;
    assign ovalid     = ovalid_q;
    assign oerr       = oerr_q;

endmodule

// File: tb/tb_ads7254_sample_avg.sv
// Directed self-checking bench for ads7254_sample_avg with LOG2_N=3 and mid-scale offsets.
// Inputs change on the falling edge; outputs are read on the falling edge or 2 ns after the rising edge.
module tb_ads7254_sample_avg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sync = 1'b0;
    logic        vld = 1'b0;
    logic [11:0] da = '0;
    logic [11:0] db = '0;
    logic [15:0] oa, ob;
    logic        ovalid, oerr;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned pcyc[$];
    logic [15:0] pa[$];
    logic [15:0] pb[$];

    ads7254_sample_avg #(
        .DATA_W  (12),
        .LOG2_N  (3),
        .OFFSET_A(2048),
        .OFFSET_B(2048)
    ) dut (
        .iCLK_100  (clk),
        .iRST      (rst),
        .iSYNC     (sync),
        .ivalid    (vld),
        .idata_ch_A(da),
        .idata_ch_B(db),
        .odata_ch_A(oa),
        .odata_ch_B(ob),
        .ovalid    (ovalid),
        .oerr      (oerr)
    );

    always #5 clk = ~clk;

    // Log every output strobe with its cycle number and data.
    always @(posedge clk) begin
        cyc++;
        #2;
        if (ovalid === 1'b1) begin
            pcyc.push_back(cyc);
            pa.push_back(oa);
            pb.push_back(ob);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [11:0] a, input logic [11:0] b);
        vld = 1'b1;
        da  = a;
        db  = b;
        @(negedge clk);
        vld = 1'b0;
    endtask

    task automatic pulse_sync();
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        checks++; if (oa !== 16'h0000) begin errors++; $display("FAIL reset_oa got %h want 0000", oa); end
        checks++; if (ob !== 16'h0000) begin errors++; $display("FAIL reset_ob got %h want 0000", ob); end
        checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL reset_ovalid got %b want 0", ovalid); end
        checks++; if (oerr !== 1'b0) begin errors++; $display("FAIL reset_oerr got %b want 0", oerr); end
        for (int i = 0; i < 8; i++) begin
            send(12'hFFF, 12'hFFF);
            idle(3);
        end
        checks++; if (pcyc.size() !== 0) begin errors++; $display("FAIL nosync_pulses got %0d want 0", pcyc.size()); end
        checks++; if (oa !== 16'h0000) begin errors++; $display("FAIL nosync_oa got %h want 0000", oa); end
        checks++; if (ob !== 16'h0000) begin errors++; $display("FAIL nosync_ob got %h want 0000", ob); end
    endtask

    task automatic test_basic();
        int n0;
        pulse_sync();
        n0 = pcyc.size();
        for (int i = 0; i < 8; i++) begin
            send(12'hFFF, 12'h000);
            if (i == 6) begin
                checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL basic_early got %b want 0", ovalid); end
            end
            if (i < 7) idle(23);
        end
        checks++; if (ovalid !== 1'b1) begin errors++; $display("FAIL basic_ovalid got %b want 1", ovalid); end
        checks++; if (oa !== 16'h07FF) begin errors++; $display("FAIL basic_oa got %h want 07ff", oa); end
        checks++; if (ob !== 16'hF800) begin errors++; $display("FAIL basic_ob got %h want f800", ob); end
        idle(1);
        checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL basic_strobe_len got %b want 0", ovalid); end
        checks++; if (oa !== 16'h07FF) begin errors++; $display("FAIL basic_hold got %h want 07ff", oa); end
        checks++; if (pcyc.size() - n0 !== 1) begin errors++; $display("FAIL basic_pulses got %0d want 1", pcyc.size() - n0); end
    endtask

    task automatic test_rounding();
        // A: 8x2047 -> -1; B: 8x2048 -> 0
        for (int i = 0; i < 8; i++) send(12'h7FF, 12'h800);
        checks++; if (ovalid !== 1'b1) begin errors++; $display("FAIL rnd1_ovalid got %b want 1", ovalid); end
        checks++; if (oa !== 16'hFFFF) begin errors++; $display("FAIL rnd1_oa got %h want ffff", oa); end
        checks++; if (ob !== 16'h0000) begin errors++; $display("FAIL rnd1_ob got %h want 0000", ob); end
        // A: 7x2048 + 2049 -> 1>>>3 = 0; B: 7x2047 + 2048 -> -7>>>3 = -1
        for (int i = 0; i < 7; i++) send(12'h800, 12'h7FF);
        send(12'h801, 12'h800);
        checks++; if (oa !== 16'h0000) begin errors++; $display("FAIL rnd2_oa got %h want 0000", oa); end
        checks++; if (ob !== 16'hFFFF) begin errors++; $display("FAIL rnd2_ob got %h want ffff", ob); end
        for (int i = 0; i < 7; i++) send(12'h7FF, 12'h800);
        send(12'h800, 12'h801);
        checks++; if (oa !== 16'hFFFF) begin errors++; $display("FAIL rnd3_oa got %h want ffff", oa); end
        checks++; if (ob !== 16'h0000) begin errors++; $display("FAIL rnd3_ob got %h want 0000", ob); end
        idle(2);
    endtask

    task automatic test_truncate();
        int n0;
        pulse_sync();
        checks++; if (oerr !== 1'b0) begin errors++; $display("FAIL trunc_clean_sync got %b want 0", oerr); end
        n0 = pcyc.size();
        for (int i = 0; i < 5; i++) begin
            send(12'h900, 12'h900);
            idle(2);
        end
        pulse_sync();
        idle(1);
        checks++; if (oerr !== 1'b1) begin errors++; $display("FAIL trunc_oerr got %b want 1", oerr); end
        checks++; if (pcyc.size() - n0 !== 0) begin errors++; $display("FAIL trunc_pulses got %0d want 0", pcyc.size() - n0); end
        for (int i = 0; i < 8; i++) send(12'h900, 12'h700);
        checks++; if (ovalid !== 1'b1) begin errors++; $display("FAIL trunc_next_ovalid got %b want 1", ovalid); end
        checks++; if (oa !== 16'h0100) begin errors++; $display("FAIL trunc_next_oa got %h want 0100", oa); end
        checks++; if (ob !== 16'hFF00) begin errors++; $display("FAIL trunc_next_ob got %h want ff00", ob); end
        checks++; if (oerr !== 1'b1) begin errors++; $display("FAIL trunc_sticky got %b want 1", oerr); end
        idle(2);
    endtask

    task automatic test_coincident();
        int n0;
        n0 = pcyc.size();
        sync = 1'b1;
        send(12'hFFF, 12'h000);
        sync = 1'b0;
        for (int i = 0; i < 7; i++) send(12'h800, 12'h800);
        checks++; if (ovalid !== 1'b1) begin errors++; $display("FAIL coinc_ovalid got %b want 1", ovalid); end
        checks++; if (oa !== 16'h00FF) begin errors++; $display("FAIL coinc_oa got %h want 00ff", oa); end
        checks++; if (ob !== 16'hFF00) begin errors++; $display("FAIL coinc_ob got %h want ff00", ob); end
        checks++; if (pcyc.size() - n0 !== 1) begin errors++; $display("FAIL coinc_pulses got %0d want 1", pcyc.size() - n0); end
        idle(2);
    endtask

    task automatic test_back_to_back();
        int n0;
        pulse_sync();
        n0 = pcyc.size();
        for (int i = 0; i < 8; i++) send(12'h810, 12'h800);
        for (int i = 0; i < 8; i++) send(12'h7F0, 12'h808);
        for (int i = 0; i < 3; i++) send(12'h900, 12'h900);
        checks++; if (pcyc.size() - n0 !== 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", pcyc.size() - n0); end
        if (pcyc.size() - n0 == 2) begin
            checks++; if (pcyc[n0+1] - pcyc[n0] !== 8) begin errors++; $display("FAIL b2b_spacing got %0d want 8", pcyc[n0+1] - pcyc[n0]); end
            checks++; if (pa[n0] !== 16'h0010) begin errors++; $display("FAIL b2b_w1_oa got %h want 0010", pa[n0]); end
            checks++; if (pb[n0] !== 16'h0000) begin errors++; $display("FAIL b2b_w1_ob got %h want 0000", pb[n0]); end
            checks++; if (pa[n0+1] !== 16'hFFF0) begin errors++; $display("FAIL b2b_w2_oa got %h want fff0", pa[n0+1]); end
            checks++; if (pb[n0+1] !== 16'h0008) begin errors++; $display("FAIL b2b_w2_ob got %h want 0008", pb[n0+1]); end
        end
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        checks++; if (oa !== 16'h0000) begin errors++; $display("FAIL rst2_oa got %h want 0000", oa); end
        checks++; if (ob !== 16'h0000) begin errors++; $display("FAIL rst2_ob got %h want 0000", ob); end
        checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL rst2_ovalid got %b want 0", ovalid); end
        checks++; if (oerr !== 1'b0) begin errors++; $display("FAIL rst2_oerr got %b want 0", oerr); end
        n0 = pcyc.size();
        for (int i = 0; i < 8; i++) send(12'h900, 12'h900);
        idle(2);
        checks++; if (pcyc.size() - n0 !== 0) begin errors++; $display("FAIL rst2_idle_pulses got %0d want 0", pcyc.size() - n0); end
        pulse_sync();
        for (int i = 0; i < 8; i++) send(12'h900, 12'h880);
        checks++; if (ovalid !== 1'b1) begin errors++; $display("FAIL rst2_win_ovalid got %b want 1", ovalid); end
        checks++; if (oa !== 16'h0100) begin errors++; $display("FAIL rst2_win_oa got %h want 0100", oa); end
        checks++; if (ob !== 16'h0080) begin errors++; $display("FAIL rst2_win_ob got %h want 0080", ob); end
        checks++; if (oerr !== 1'b0) begin errors++; $display("FAIL rst2_win_oerr got %b want 0", oerr); end
        idle(2);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_rounding();
        test_truncate();
        test_coincident();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ads7254_sample_avg.md
Name: ads7254_sample_avg

Overview:
- Sits directly downstream of the ADS7254 dual-channel serial ADC interface.
- Consumes its 12-bit unsigned channel A/B sample pairs and removes a fixed mid-scale offset, giving signed values.
- Averages the pairs over a boxcar window of 2^LOG2_N samples that is aligned to the PWM/control iSYNC edge.
- Emits one signed averaged pair per window with a single-cycle valid strobe for the control loop.

Parameters:
- DATA_W, 12: ADC sample width (unsigned input).
- LOG2_N, 3: log2 of window length. Legal range 0..6; 0 means pass-through with offset removal only.
- OFFSET_A, 2048: unsigned value subtracted from channel A samples.
- OFFSET_B, 2048: unsigned value subtracted from channel B samples.

Ports:
- iCLK_100  in  1  system clock (100 MHz); the only clock.
- iRST  in  1  reset, synchronous, active-high.
- iSYNC  in  1  window alignment, already in the iCLK_100 domain; the rising edge restarts the window.
- ivalid  in  1  one-cycle strobe; idata_ch_A/B are valid in that cycle.
- idata_ch_A  in  DATA_W  channel A sample, unsigned.
- idata_ch_B  in  DATA_W  channel B sample, unsigned.
- odata_ch_A  out  16  averaged channel A, two's complement.
- odata_ch_B  out  16  averaged channel B, two's complement.
- ovalid  out  1  one-cycle strobe marking new odata values.
- oerr  out  1  sticky flag: a partial window was discarded.

Behaviour:
- Reset: every register updates on the iCLK_100 rising edge while iRST=1.
  - Reset values: state=WAIT_SYNC, accumulators=0, cnt=0, sync_d=0, odata_ch_A=0, odata_ch_B=0, ovalid=0, oerr=0.
  - Reset asserted mid-window discards that window silently; oerr is not set.
- Edge detect: sync_rise = iSYNC & ~sync_d, with sync_d registered every cycle.
- Offset step: s = {1'b0, idata} - OFFSET, held as DATA_W+1 bits signed, per channel.
- Accumulators: DATA_W+1+LOG2_N bits signed per channel. No overflow is possible by construction.
- Window counter cnt: LOG2_N+1 bits.
- State machine:
  - WAIT_SYNC: ivalid is ignored. On sync_rise go to ACCUM with acc=0 and cnt=0. If ivalid is also high in that cycle, acc=s and cnt=1.
  - ACCUM, ivalid without sync_rise: acc+=s and cnt++.
  - ACCUM, completing sample: the ivalid that brings cnt to 2^LOG2_N registers odata = (acc+s) >>> LOG2_N on the same edge.
    - The shift is arithmetic, truncating toward minus infinity.
    - The result is sign-extended to 16 bits.
    - ovalid=1 for exactly the next cycle. acc=0, cnt=0, state stays ACCUM.
  - ACCUM, sync_rise: restart the window (acc=0, cnt=0). If cnt!=0 at the time, set oerr=1.
  - ACCUM, sync_rise together with ivalid: the restart wins and the sample is the first of the new window (acc=s, cnt=1). If the restart truncates a window, no ovalid is produced for it.
- Latency: ovalid is high in the cycle after the ivalid carrying the window's last sample.
- odata holds its value between strobes.
- Back-to-back ivalid (every cycle) is supported with no sample loss across window boundaries.
- LOG2_N=0: every ivalid yields ovalid in the next cycle, with odata = s sign-extended.
- oerr is cleared only by iRST.

Test Plan:
1. Reset, iSYNC held 0, 8 ivalid pulses with A=B=0xFFF -> ovalid never asserted, odata_ch_A/B=0x0000.
2. iSYNC rise, then 8 ivalid with A=0xFFF and B=0x000, spaced 24 cycles -> one ovalid pulse the cycle after the 8th ivalid; odata_ch_A=0x07FF (2047), odata_ch_B=0xF800 (-2048).
3. Rounding checks:
   - 8 samples all 2047 -> 0xFFFF (-1).
   - 7×2048 plus 1×2049 -> 0x0000.
   - 7×2047 plus 1×2048 -> -7>>>3 = 0xFFFF.
4. iSYNC rise after 5 samples -> no ovalid and oerr=1. The next 8 samples of 0x900 -> odata=0x0100; oerr stays 1.
5. iSYNC rise coincident with ivalid (A=0xFFF), followed by 7 samples of 0x800 -> odata_ch_A=2047>>>3=0x00FF, so the coincident sample is counted.
6. 16 back-to-back ivalid cycles, then iRST pulsed mid-window after 3 further samples:
   - Two ovalid pulses exactly 8 cycles apart.
   - After reset, all outputs are 0, oerr=0, and nothing is accumulated until the next iSYNC rise.
